// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_controller
// Description : Multi-source interrupt controller feeding a single-line core
//               request/acknowledge interface. Each source is individually
//               edge- or level-sensitive and maskable. The lowest eligible
//               index wins, or a rotating priority is used when the macro
//               INTC_ROTATE_PRIORITY_EN is defined. One request is tracked
//               from presentation through acknowledge to return-from-ISR.
//
// Ports       : clk         - clock, all logic on rising edge
//               reset       - synchronous active-high reset
//               irq_in      - interrupt sources (synchronous to clk)
//               mask_we     - enable-mask write strobe
//               mask_wdata  - new enable mask (1 = enabled)
//               int_ack     - core accepts the presented request
//               int_done    - core executed return-from-interrupt
//               int_req     - interrupt request to the core
//               int_vector  - ISR address of the presented source
//               int_id      - index of the presented source
//               pending     - raw pending bits, before masking
//               in_service  - high while an ISR is executing
//
// Config      : INTC_ROTATE_PRIORITY_EN - rotating priority after each ack
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_controller #(
    parameter int                     NUM_SOURCES   = 4,
    parameter logic [NUM_SOURCES-1:0] EDGE_MASK     = {NUM_SOURCES{1'b1}},
    parameter logic [NUM_SOURCES-1:0] RESET_MASK    = {NUM_SOURCES{1'b1}},
    parameter logic [7:0]             VECTOR_BASE   = 8'h80,
    parameter logic [7:0]             VECTOR_STRIDE = 8'h04,
    parameter int                     ID_W          = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] irq_in,
    input  logic                   mask_we,
    input  logic [NUM_SOURCES-1:0] mask_wdata,
    input  logic                   int_ack,
    input  logic                   int_done,
    output logic                   int_req,
    output logic [7:0]             int_vector,
    output logic [ID_W-1:0]        int_id,
    output logic [NUM_SOURCES-1:0] pending,
    output logic                   in_service
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQUEST = 2'd1;
    localparam logic [1:0] S_SERVICE = 2'd2;

    localparam logic [NUM_SOURCES-1:0] c_ONE = NUM_SOURCES'(1);

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [NUM_SOURCES-1:0] r_irq_prev;
    logic [NUM_SOURCES-1:0] r_pend_edge;
    logic [NUM_SOURCES-1:0] r_mask;
    logic [NUM_SOURCES-1:0] w_rise;
    logic [NUM_SOURCES-1:0] w_clr;
    logic [NUM_SOURCES-1:0] w_eligible;
    logic [ID_W-1:0]        r_id;
    logic [ID_W-1:0]        w_win_id;
    logic [7:0]             r_vector;
    logic [7:0]             w_win_vector;
    logic                   w_win_found;
    logic                   w_ack_fire;

    // Index of the lowest set bit; callers only use it when the vector is non-zero.
    function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_SOURCES-1:0] v);
        logic [ID_W-1:0]        idx;
        logic [NUM_SOURCES-1:0] t;
        idx = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            t = v >> i;
            if (t[0]) begin
                idx = ID_W'(i);
            end
        end
        return idx;
    endfunction

    // ------------------------------------------------------------------------
    // Pending tracking
    // ------------------------------------------------------------------------
    assign w_ack_fire = (r_state == S_REQUEST) && int_ack;
    assign w_rise     = irq_in & ~r_irq_prev & EDGE_MASK;
    // Only edge sources hold latched state, so only they are cleared on ack.
    assign w_clr      = w_ack_fire ? (EDGE_MASK & (c_ONE << r_id)) : '0;

    // Level sources bypass the latch and follow irq_in directly.
    assign pending    = r_pend_edge | (irq_in & ~EDGE_MASK);
    assign w_eligible = pending & r_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_prev  <= '0;
            r_pend_edge <= '0;
            r_mask      <= RESET_MASK;
        end else begin
            r_irq_prev  <= irq_in;
            // A new edge on the acked source in the same cycle survives the clear.
            r_pend_edge <= (r_pend_edge & ~w_clr) | w_rise;
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    assign w_win_found = |w_eligible;

`ifdef INTC_ROTATE_PRIORITY_EN
    logic [ID_W-1:0]        r_ptr;
    logic [NUM_SOURCES-1:0] w_upper;

    // Sources at or above the pointer are searched first, then wrap to the bottom.
    assign w_upper  = w_eligible & ~((c_ONE << r_ptr) - c_ONE);
    assign w_win_id = (|w_upper) ? lowest_set(w_upper) : lowest_set(w_eligible);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_ack_fire) begin
            if (r_id == ID_W'(NUM_SOURCES - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= r_id + ID_W'(1);
            end
        end
    end
`else
    assign w_win_id = lowest_set(w_eligible);
`endif

    // 8-bit arithmetic: the vector wraps modulo 256 by construction.
    assign w_win_vector = VECTOR_BASE + (8'(w_win_id) * VECTOR_STRIDE);

    // Winner is captured on entry to REQUEST and held until the next grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_id     <= '0;
            r_vector <= VECTOR_BASE;
        end else if ((r_state == S_IDLE) && w_win_found) begin
            r_id     <= w_win_id;
            r_vector <= w_win_vector;
        end
    end

    assign int_id     = r_id;
    assign int_vector = r_vector;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_win_found) begin
                    w_state_next = S_REQUEST;
                end
            end
            S_REQUEST: begin
                if (int_ack) begin
                    w_state_next = S_SERVICE;
                end
            end
            S_SERVICE: begin
                if (int_done) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        int_req    = 1'b0;
        in_service = 1'b0;
        case (r_state)
            S_REQUEST: int_req    = 1'b1;
            S_SERVICE: in_service = 1'b1;
            default: begin
                int_req    = 1'b0;
                in_service = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_controller
// Description : Scoreboard bench for interrupt_controller. Two instances share
//               all stimulus: A uses VECTOR_BASE 8'h80, B uses 8'hF8 (vector
//               wrap). Both use EDGE_MASK 4'b1110 (source 0 level-sensitive).
//               Stimulus pushes the expected grant (id, cycle) into a queue;
//               a monitor pops and compares on each rising int_req.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_controller;

    typedef struct {
        logic [1:0] id;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic       int_ack;
    logic       int_done;

    logic       a_req, a_insvc, b_req, b_insvc;
    logic [7:0] a_vec, b_vec;
    logic [1:0] a_id, b_id;
    logic [3:0] a_pend, b_pend;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_q[$];
    exp_t e;
    logic mon_prev = 1'b0;
    logic [1:0] first_id, second_id;
    logic [3:0] rem_pend;

    logic [7:0] c_vec_a [4] = '{8'h80, 8'h84, 8'h88, 8'h8C};
    logic [7:0] c_vec_b [4] = '{8'hF8, 8'hFC, 8'h00, 8'h04};

    interrupt_controller #(
        .NUM_SOURCES(4), .EDGE_MASK(4'b1110), .RESET_MASK(4'b1111),
        .VECTOR_BASE(8'h80), .VECTOR_STRIDE(8'h04)
    ) u_dut_a (
        .clk(clk), .reset(reset), .irq_in(irq), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .int_ack(int_ack), .int_done(int_done),
        .int_req(a_req), .int_vector(a_vec), .int_id(a_id),
        .pending(a_pend), .in_service(a_insvc)
    );

    interrupt_controller #(
        .NUM_SOURCES(4), .EDGE_MASK(4'b1110), .RESET_MASK(4'b1111),
        .VECTOR_BASE(8'hF8), .VECTOR_STRIDE(8'h04)
    ) u_dut_b (
        .clk(clk), .reset(reset), .irq_in(irq), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .int_ack(int_ack), .int_done(int_done),
        .int_req(b_req), .int_vector(b_vec), .int_id(b_id),
        .pending(b_pend), .in_service(b_insvc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [1:0] id, input int dly);
        exp_t x;
        x.id  = id;
        x.cyc = cyc + dly;
        exp_q.push_back(x);
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!a_req && n < 20) begin
            tick(1);
            n++;
        end
        chk("req_timeout", {31'd0, a_req}, 32'd1);
    endtask

    task automatic do_ack();
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        chk("ack_req_low", {31'd0, a_req}, 32'd0);
        chk("ack_in_service", {31'd0, a_insvc}, 32'd1);
    endtask

    task automatic do_done();
        int_done = 1'b1;
        tick(1);
        int_done = 1'b0;
        chk("done_in_service", {31'd0, a_insvc}, 32'd0);
    endtask

    // Monitor: every new request is matched against the head of the queue.
    always @(negedge clk) begin
        if (a_req && !mon_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant actual id=%0d required none", a_id);
            end else begin
                e = exp_q.pop_front();
                chk("grant_id_a", {30'd0, a_id}, {30'd0, e.id});
                chk("grant_vec_a", {24'd0, a_vec}, {24'd0, c_vec_a[e.id]});
                chk("grant_id_b", {30'd0, b_id}, {30'd0, e.id});
                chk("grant_vec_b", {24'd0, b_vec}, {24'd0, c_vec_b[e.id]});
                chk("grant_req_b", {31'd0, b_req}, 32'd1);
                chk("grant_cycle", cyc, e.cyc);
            end
        end
        mon_prev = a_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; irq = '0; mask_we = 1'b0; mask_wdata = '0;
        int_ack = 1'b0; int_done = 1'b0;
        tick(3);
        reset = 1'b0;

        // Reset state
        chk("rst_req", {31'd0, a_req}, 32'd0);
        chk("rst_in_service", {31'd0, a_insvc}, 32'd0);
        chk("rst_id", {30'd0, a_id}, 32'd0);
        chk("rst_vec_a", {24'd0, a_vec}, 32'h80);
        chk("rst_vec_b", {24'd0, b_vec}, 32'hF8);
        chk("rst_pending", {28'd0, a_pend}, 32'd0);
        tick(1);

        // Reset while in REQUEST with sources 1 and 2 pending
        irq = 4'b0110; push(2'd1, 2);
        tick(1);
        irq = 4'b0000;
        wait_req();
        reset = 1'b1;
        tick(1);
        chk("midrst_req", {31'd0, a_req}, 32'd0);
        chk("midrst_pending", {28'd0, a_pend}, 32'd0);
        chk("midrst_vec_a", {24'd0, a_vec}, 32'h80);
        chk("midrst_vec_b", {24'd0, b_vec}, 32'hF8);
        chk("midrst_in_service", {31'd0, a_insvc}, 32'd0);
        reset = 1'b0;
        tick(3);
        chk("midrst_stays_idle", {31'd0, a_req}, 32'd0);

        // Single edge on source 2
        irq = 4'b0100; push(2'd2, 2);
        tick(1);
        irq = 4'b0000;
        chk("edge2_pending", {28'd0, a_pend}, 32'h4);
        wait_req();
        do_ack();
        chk("edge2_pending_cleared", {28'd0, a_pend}, 32'd0);
        do_done();
        tick(2);
        chk("edge2_idle", {31'd0, a_req}, 32'd0);

        // Simultaneous edges on sources 1 and 3
`ifdef INTC_ROTATE_PRIORITY_EN
        first_id = 2'd3; second_id = 2'd1; rem_pend = 4'b0010;
`else
        first_id = 2'd1; second_id = 2'd3; rem_pend = 4'b1000;
`endif
        irq = 4'b1010; push(first_id, 2);
        tick(1);
        irq = 4'b0000;
        wait_req();
        do_ack();
        chk("dual_remaining", {28'd0, a_pend}, {28'd0, rem_pend});
        push(second_id, 2);
        do_done();
        wait_req();
        do_ack();
        do_done();

        // Masked source 3, then unmasked
        mask_we = 1'b1; mask_wdata = 4'b0111;
        tick(1);
        mask_we = 1'b0;
        irq = 4'b1000;
        tick(1);
        irq = 4'b0000;
        tick(4);
        chk("masked_no_req", {31'd0, a_req}, 32'd0);
        chk("masked_pending", {28'd0, a_pend}, 32'h8);
        mask_we = 1'b1; mask_wdata = 4'b1111; push(2'd3, 2);
        tick(1);
        mask_we = 1'b0;
        wait_req();
        do_ack();
        do_done();

        // Level source 0 held through int_done, then dropped
        irq = 4'b0001; push(2'd0, 1);
        wait_req();
        do_ack();
        chk("level_pending_held", {28'd0, a_pend}, 32'h1);
        push(2'd0, 2);
        do_done();
        wait_req();
        do_ack();
        irq = 4'b0000;
        tick(1);
        do_done();
        tick(3);
        chk("level_dropped_idle", {31'd0, a_req}, 32'd0);
        chk("level_dropped_pending", {28'd0, a_pend}, 32'd0);

        // Ack and done outside their states are ignored
        int_ack = 1'b1; int_done = 1'b1;
        tick(1);
        int_ack = 1'b0; int_done = 1'b0;
        chk("ignored_req", {31'd0, a_req}, 32'd0);
        chk("ignored_in_service", {31'd0, a_insvc}, 32'd0);

        // New edge on the winner in the same cycle as its ack
        irq = 4'b0100; push(2'd2, 2);
        tick(1);
        irq = 4'b0000;
        wait_req();
        int_ack = 1'b1; irq = 4'b0100;
        tick(1);
        int_ack = 1'b0; irq = 4'b0000;
        chk("ack_edge_pending", {28'd0, a_pend}, 32'h4);
        chk("ack_edge_in_service", {31'd0, a_insvc}, 32'd1);
        push(2'd2, 2);
        do_done();
        wait_req();
        do_ack();
        do_done();

        tick(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_grant actual=none required id=%0d", e.id);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/interrupt_controller.md
# interrupt_controller

Parametrised multi-source interrupt controller sitting between peripherals (PWM channels, timers) and the `cpu_top` core. It extends the single `int_req`/`int_ack` line into `NUM_SOURCES` maskable inputs, each individually edge- or level-sensitive. It arbitrates by priority and presents the winning source's ISR vector and ID to the core. It tracks one in-service interrupt until the core signals return-from-interrupt.

## Interface
- `NUM_SOURCES`, 4: number of interrupt inputs, 1..16.
- `EDGE_MASK`, all ones: bit i = 1 makes source i rising-edge sensitive; 0 makes it level sensitive.
- `RESET_MASK`, all ones: enable-mask value loaded at reset.
- `VECTOR_BASE`, 8'h80: ISR address of source 0.
- `VECTOR_STRIDE`, 8'h04: address spacing between consecutive source ISRs.
- `ID_W`, max(1, $clog2(NUM_SOURCES)): width of the source ID.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `irq_in` in NUM_SOURCES: interrupt sources, synchronous to `clk`.
- `mask_we` in 1: write strobe for the enable mask.
- `mask_wdata` in NUM_SOURCES: new enable mask; bit = 1 means enabled.
- `int_ack` in 1: core accepts the current request.
- `int_done` in 1: one-cycle pulse, core executed RETI.
- `int_req` out 1: interrupt request to the core.
- `int_vector` out 8: ISR address of the presented source.
- `int_id` out ID_W: index of the presented source.
- `pending` out NUM_SOURCES: raw pending bits, before masking.
- `in_service` out 1: high while an ISR is executing.

## Operation
- Edge source: register `irq_prev` per source. A rising edge (`irq_in & ~irq_prev`) sets the pending bit. The bit clears only when that source's request is acked. A further edge while the bit is pending is absorbed; there is no event counting.
- Level source: the pending bit equals `irq_in` directly and is never latched. The device must drop `irq_in` before `int_done`, otherwise the source is requested again.
- Eligible set = `pending & mask`. The mask updates on `mask_we` at the next edge.
- Fixed priority: the lowest eligible index wins.
- `int_vector` = (`VECTOR_BASE` + `int_id`*`VECTOR_STRIDE`) mod 256. The 8-bit sum wraps with no error.
- FSM states: IDLE, REQUEST, SERVICE.
  - IDLE -> REQUEST: when the eligible set is non-zero. Register the winner's ID and vector, and set `int_req`.
  - REQUEST -> SERVICE: on `int_ack` = 1. Clear `int_req`, clear the winner's pending bit if it is an edge source, and set `in_service`.
  - SERVICE -> IDLE: on `int_done` = 1. Clear `in_service`.
- No nesting: new events only accumulate in `pending` while in REQUEST or SERVICE.
- A request is committed once in REQUEST. Later mask writes or a level drop do not withdraw it; `int_id` and `int_vector` stay stable until ack.
- Ignored inputs: `int_ack` outside REQUEST; `int_done` outside SERVICE.
- Edge arriving on the winner in the same cycle as ack: the set wins and the bit stays pending, so the event is not lost.

## Timing
- Reset values:
  - `int_req` = 0, `in_service` = 0.
  - `int_id` = 0, `int_vector` = `VECTOR_BASE`.
  - `pending` = 0, `irq_prev` = 0, mask = `RESET_MASK`.
  - FSM in IDLE.
- Reset mid-operation discards the in-flight request and all pending bits at the next edge.
- Edge source: `irq_in` first sampled high at edge t sets pending at t; `int_req` goes high after edge t+1. Latency is 2 cycles.
- Level source: `int_req` goes high after the edge following the first sample of `irq_in` high. Latency is 1 cycle.
- `int_ack` sampled high at edge t: `int_req` is low after t.
- `int_done` at edge t: IDLE after t. A waiting eligible source raises `int_req` after t+1.
- Minimum spacing between two serviced interrupts is therefore 2 cycles after `int_done`.

## Configuration
- `INTC_ROTATE_PRIORITY_EN` defined:
  - Rotating priority: after an ack of source k, search starts at (k+1) mod NUM_SOURCES.
  - The rotation pointer resets to 0.
  - With NUM_SOURCES = 1 it has no effect.
- Undefined: fixed priority (lowest index wins); no pointer register is built.

## Test plan
- Edge on source 2 only, mask all ones, defaults -> `int_req` 2 cycles later with `int_id` = 2 and `int_vector` = 8'h88; ack -> `pending[2]` = 0; `int_done` -> IDLE.
- Edges on sources 1 and 3 in the same cycle (fixed priority) -> source 1 presented first (8'h84). After `int_done`, source 3 presented (8'h8C) 2 cycles later.
- Mask = 4'b0111, edge on 3 -> no `int_req`. Then mask = 4'b1111 -> `int_req` with `int_id` = 3 one cycle after the write.
- Level source 0 (`EDGE_MASK` = 4'b1110) held high through `int_done` -> re-requested 2 cycles later. Dropped before `int_done` -> stays IDLE.
- Assert `reset` while in REQUEST with sources 1 and 2 pending -> next cycle `int_req` = 0, `pending` = 0, `int_vector` = 8'h80.
- `INTC_ROTATE_PRIORITY_EN` with sources 0 and 1 held pending (level mode) -> grant order 0, 1, 0, 1.
- `VECTOR_BASE` = 8'hF8 -> source 3 vector wraps to 8'h04.
